// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
//   Shared definitions for the serial DAC transmitter: frame geometry, the
//   default configuration nibble, the FSM state encoding and the registered
//   SPI pin bundle.
// -----------------------------------------------------------------------------
package dac_pkg;

    localparam int FRAME_W = 16;                // bits per SPI frame
    localparam int DATA_W  = 12;                // DAC code width
    localparam int CFG_W   = FRAME_W - DATA_W;  // control nibble width

    // Channel A, unbuffered, gain 1x, output active.
    localparam logic [CFG_W-1:0] CFG_BITS_DEFAULT = 4'b0011;

    localparam int HCNT_W = 8;  // half-period counter width
    localparam int BCNT_W = 5;  // rising-edge counter width (saturates at 16)

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        CS_HOLD,
        LATCH
    } dac_state_t;

    // All four pins live in one register so they change together on the
    // same clk edge and never glitch.
    typedef struct packed {
        logic cs_n;
        logic sck;
        logic sdi;
        logic ldac_n;
    } spi_pins_t;

    localparam spi_pins_t SPI_IDLE = '{cs_n: 1'b1, sck: 1'b0, sdi: 1'b0, ldac_n: 1'b1};

    // Frame layout on the wire: control nibble first, then the code MSB first.
    function automatic logic [FRAME_W-1:0] build_frame(input logic [CFG_W-1:0]  cfg,
                                                       input logic [DATA_W-1:0] data);
        return {cfg, data};
    endfunction

endpackage

// File: rtl/sck_tick_gen.sv
// -----------------------------------------------------------------------------
// sck_tick_gen
//   Half-period timebase for the SPI clock. tick is high on the last clk
//   cycle of every CLK_DIV-cycle interval. restart forces the count back to
//   zero so the next interval begins on the following cycle; the FSM raises
//   it on every state change and while idle.
//
// Ports
//   clk     : clock
//   rst_n   : synchronous active-low reset
//   restart : reload the counter (interval restarts next cycle)
//   tick    : last cycle of the current half-period
// -----------------------------------------------------------------------------
module sck_tick_gen
    import dac_pkg::*;
#(
    parameter int CLK_DIV = 2   // clk cycles per half-period, 1..255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam logic [HCNT_W-1:0] LAST = HCNT_W'(CLK_DIV - 1);

    logic [HCNT_W-1:0] cnt;

    // With CLK_DIV=1 LAST is zero, so tick is simply always high.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// -----------------------------------------------------------------------------
// dac_spi_tx
//   Streams 12-bit DAC codes to a 16-bit-frame SPI DAC. A one-entry buffer
//   decouples the sample handshake from the serial frame; each frame is
//   SETUP (cs low), 32 SCK half-periods, CS_HOLD, then an LDAC pulse.
//   Every phase lasts a multiple of CLK_DIV, giving 35*CLK_DIV cycles/frame.
//
// Ports
//   clk          : clock
//   rst_n        : synchronous active-low reset (aborts a frame, no LDAC)
//   sample       : 12-bit unsigned DAC code
//   sample_valid : sample is valid this cycle
//   sample_ready : sample is accepted this cycle when valid
//   dac_cs_n     : SPI chip select, active low
//   dac_sck      : SPI clock, idle low
//   dac_sdi      : SPI data, MSB first, changes on SCK falling edges
//   dac_ldac_n   : DAC latch strobe, active low
//   busy         : a frame is in progress (state != IDLE)
// -----------------------------------------------------------------------------
module dac_spi_tx
    import dac_pkg::*;
#(
    parameter int               CLK_DIV  = 2,
    parameter logic [CFG_W-1:0] CFG_BITS = CFG_BITS_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              dac_cs_n,
    output logic              dac_sck,
    output logic              dac_sdi,
    output logic              dac_ldac_n,
    output logic              busy
);

    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(FRAME_W);

    dac_state_t         state, state_nxt;
    spi_pins_t          pins, pins_nxt;
    logic [FRAME_W-1:0] shreg, shreg_nxt;
    logic [BCNT_W-1:0]  bcnt, bcnt_nxt;

    logic               buf_full;
    logic [DATA_W-1:0]  buf_data;

    logic               tick;
    logic               restart;
    logic               load;
    logic               accept;

    // -------------------------------------------------------------------------
    // Sample buffer. The buffer is free either when empty or on the cycle its
    // content moves into the shifter, so a new sample can land the same cycle.
    // -------------------------------------------------------------------------
    assign load         = (state == IDLE) && buf_full;
    assign sample_ready = !buf_full || load;
    assign accept       = sample_valid && sample_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_full <= 1'b0;
            buf_data <= '0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_data <= sample;
        end else if (load) begin
            buf_full <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Half-period timebase. Held at zero while idle and reloaded on each
    // state change so every phase starts with a full interval.
    // -------------------------------------------------------------------------
    assign restart = (state == IDLE) || (state_nxt != state);

    sck_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // -------------------------------------------------------------------------
    // FSM next-state and next-pin logic. Pins are computed one cycle ahead
    // and registered alongside the state, so outputs line up with the state
    // they belong to and come straight from flops.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pins_nxt  = pins;
        shreg_nxt = shreg;
        bcnt_nxt  = bcnt;

        case (state)
            IDLE: begin
                if (buf_full) begin
                    shreg_nxt     = build_frame(CFG_BITS, buf_data);
                    bcnt_nxt      = '0;
                    state_nxt     = SETUP;
                    pins_nxt.cs_n = 1'b0;
                    pins_nxt.sck  = 1'b0;
                    pins_nxt.sdi  = CFG_BITS[CFG_W-1];
                end
            end

            SETUP: begin
                // First SHIFT half-period is high: the opening rising edge.
                if (tick) begin
                    state_nxt    = SHIFT;
                    pins_nxt.sck = 1'b1;
                    bcnt_nxt     = bcnt + 1'b1;
                end
            end

            SHIFT: begin
                if (tick) begin
                    if (pins.sck) begin
                        // Falling edge: advance to the next bit. Rotating keeps
                        // the whole word live; the wrapped bits are never sent.
                        pins_nxt.sck = 1'b0;
                        shreg_nxt    = {shreg[FRAME_W-2:0], shreg[FRAME_W-1]};
                        pins_nxt.sdi = shreg[FRAME_W-2];
                    end else if (bcnt == LAST_BIT) begin
                        // Low half-period after the 16th falling edge is done.
                        state_nxt     = CS_HOLD;
                        pins_nxt.cs_n = 1'b1;
                    end else begin
                        pins_nxt.sck = 1'b1;
                        bcnt_nxt     = (bcnt == LAST_BIT) ? bcnt : bcnt + 1'b1;
                    end
                end
            end

            CS_HOLD: begin
                if (tick) begin
                    state_nxt       = LATCH;
                    pins_nxt.ldac_n = 1'b0;
                end
            end

            LATCH: begin
                if (tick) begin
                    state_nxt       = IDLE;
                    pins_nxt.ldac_n = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
                pins_nxt  = SPI_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            pins  <= SPI_IDLE;
            shreg <= '0;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            pins  <= pins_nxt;
            shreg <= shreg_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    assign dac_cs_n   = pins.cs_n;
    assign dac_sck    = pins.sck;
    assign dac_sdi    = pins.sdi;
    assign dac_ldac_n = pins.ldac_n;
    assign busy       = (state != IDLE);

endmodule
